pulse_gen: RTL and testbench
============================

Name: pulse_gen

Overview:
- Converts single-cycle event pulses back into timed levels.
- Each accepted trigger produces one high level on sig_out, after a programmable delay and for a programmable width.
- Retrigger (extend) mode, abort, a drop indication and a completed-pulse counter are included.
- Sits downstream of the edge-detect logic: its rising/falling pulses feed trig to rebuild strobes, enables and timeouts for downstream blocks.

Parameters:
- CNT_W, 16, width of the delay/width counters, the cfg inputs and pulse_cnt.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- trig  input  1  single-cycle start request; a multi-cycle high is treated as one request per cycle.
- abort  input  1  synchronous abort of the current operation.
- cfg_delay  input  CNT_W  delay in cycles from acceptance to sig_out high; sampled on accept.
- cfg_width  input  CNT_W  high time in cycles; 0 is treated as 1; sampled on accept and on retrigger.
- cfg_retrig  input  1  1 means a trig in HIGH extends the pulse; 0 means it is dropped. Sampled every cycle.
- sig_out  output  1  generated level, registered.
- busy  output  1  high in DELAY or HIGH, registered.
- done  output  1  one-cycle pulse on normal completion.
- trig_drop  output  1  one-cycle pulse, the cycle after a trig was not accepted.
- pulse_cnt  output  CNT_W  count of normally completed pulses; saturates at all-ones.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; sig_out, busy, done, trig_drop = 0; pulse_cnt = 0; counters = 0. Reset mid-pulse drops sig_out the next cycle with no done.
- FSM states: IDLE, DELAY, HIGH. Let D = cfg_delay and W = max(cfg_width, 1), both sampled in accept cycle T.
- IDLE → DELAY when trig=1 and D>0. DELAY occupies cycles T+1..T+D.
- IDLE → HIGH when trig=1 and D=0.
- HIGH occupies cycles T+D+1..T+D+W. sig_out=1 exactly in HIGH, so the pulse is exactly W cycles wide.
- HIGH → IDLE after the last high cycle. In cycle T+D+W+1: done=1, and pulse_cnt increments (visible in the same cycle; saturating).
- The IDLE cycle that carries done accepts a new trig, giving back-to-back pulses with a one-cycle low gap.
- busy = 1 in DELAY and HIGH, 0 in IDLE.
- Counters are loaded on entry and decremented per cycle. No wrap-around; the maximum D or W is 2^CNT_W−1.
- Retrigger: trig in HIGH with cfg_retrig=1 reloads the width counter with the new W at cycle H. sig_out stays high through H+W, with no gap and no intermediate done.
- A trig in HIGH on the pulse's last cycle with cfg_retrig=1 also extends the pulse; no done that cycle.
- Dropped triggers: trig in HIGH with cfg_retrig=0, or trig in any DELAY cycle. The trig is ignored, the operation continues unchanged, and trig_drop=1 the following cycle.
- abort (priority below rst, above everything else):
  - From any state, the next state is IDLE and sig_out=0 the next cycle.
  - No done, no pulse_cnt increment.
  - trig in the same cycle as abort is dropped (trig_drop next cycle).
  - abort in IDLE has no effect.
- Latency: sig_out rises D+1 cycles after the accepted trig cycle.

Test Plan:
- Basic: D=0, W=4, trig at cycle 10 → sig_out high cycles 11–14, busy 11–14, done at 15, pulse_cnt 0→1 at 15.
- Delay: D=3, W=2, trig at 10 → busy 11–15, sig_out 14–15, done 16; trig at 12 → trig_drop at 13, timing unchanged.
- Width 0 and back-to-back: D=0, W=0, trig at 5 and 7 → sig_out at 6 and 8 (one cycle each), done at 7 and 9, pulse_cnt=2.
- Retrigger: D=0, W=5, cfg_retrig=1, trig at 0 and at 3 with W=5 → sig_out 1–8 continuous, single done at 9, pulse_cnt=1. Same stimulus with cfg_retrig=0 → sig_out 1–5, trig_drop at 4, done at 6.
- Abort/reset: D=2, W=10, trig at 0, abort at 5 → sig_out 3–5, low from 6, no done, pulse_cnt unchanged. rst at 4 of a fresh pulse → all outputs 0 from 5, pulse_cnt=0.
- Saturation: CNT_W=4, complete 16 pulses → pulse_cnt holds 15.

Source files
------------

// File: rtl/pulse_gen_if.sv
// Trigger/config inputs and generated-level outputs of pulse_gen.
// Master drives requests and configuration; slave drives the generated level and status.
interface pulse_gen_if #(
    parameter int CNT_W = 16
);
    logic             trig;
    logic             abort;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_width;
    logic             cfg_retrig;
    logic             sig_out;
    logic             busy;
    logic             done;
    logic             trig_drop;
    logic [CNT_W-1:0] pulse_cnt;

    modport master (
        output trig, abort, cfg_delay, cfg_width, cfg_retrig,
        input  sig_out, busy, done, trig_drop, pulse_cnt
    );

    modport slave (
        input  trig, abort, cfg_delay, cfg_width, cfg_retrig,
        output sig_out, busy, done, trig_drop, pulse_cnt
    );
endinterface

// File: rtl/pulse_gen.sv
// Rebuilds a timed level on sig_out from single-cycle trig pulses: delay D, width max(W,1).
// sig_out rises D+1 cycles after an accepted trig; no backpressure, unaccepted trigs flag trig_drop.
module pulse_gen #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    pulse_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DELAY, HIGH} state_t;

    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO = '0;
    localparam logic [CNT_W-1:0] MAX  = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] w_eff;

    assign w_eff = (bus.cfg_width == ZERO) ? ONE : bus.cfg_width;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= ZERO;
            width_q       <= ZERO;
            bus.sig_out   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.trig_drop <= 1'b0;
            bus.pulse_cnt <= ZERO;
        end else begin
            bus.done      <= 1'b0;
            bus.trig_drop <= 1'b0;
            if (bus.abort) begin
                state         <= IDLE;
                cnt           <= ZERO;
                bus.sig_out   <= 1'b0;
                bus.busy      <= 1'b0;
                bus.trig_drop <= bus.trig;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.trig) begin
                            bus.busy <= 1'b1;
                            width_q  <= w_eff;
                            if (bus.cfg_delay != ZERO) begin
                                state <= DELAY;
                                cnt   <= bus.cfg_delay;
                            end else begin
                                state       <= HIGH;
                                cnt         <= w_eff;
                                bus.sig_out <= 1'b1;
                            end
                        end
                    end
                    DELAY: begin
                        bus.trig_drop <= bus.trig;
                        // Width was captured at accept time, not at the end of the delay.
                        if (cnt == ONE) begin
                            state       <= HIGH;
                            cnt         <= width_q;
                            bus.sig_out <= 1'b1;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    HIGH: begin
                        if (bus.trig && bus.cfg_retrig) begin
                            cnt <= w_eff;
                        end else begin
                            bus.trig_drop <= bus.trig;
                            if (cnt == ONE) begin
                                state       <= IDLE;
                                cnt         <= ZERO;
                                bus.sig_out <= 1'b0;
                                bus.busy    <= 1'b0;
                                bus.done    <= 1'b1;
                                if (bus.pulse_cnt != MAX)
                                    bus.pulse_cnt <= bus.pulse_cnt + ONE;
                            end else begin
                                cnt <= cnt - ONE;
                            end
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        cnt         <= ZERO;
                        bus.sig_out <= 1'b0;
                        bus.busy    <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pulse_gen.sv
// Randomized and directed stimulus for pulse_gen against an interval-based reference model.
module tb_pulse_gen;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pulse_gen_if #(.CNT_W(CNT_W)) bus ();

    pulse_gen #(.CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int   cyc;
        logic sig_out;
        logic busy;
        logic done;
        logic trig_drop;
        int   pulse_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: the pulse is a closed interval [hi_start, hi_end] of absolute cycles.
    bit   m_active = 0;
    int   m_hi_start = 0;
    int   m_hi_end = 0;
    int   m_cnt = 0;

    int   d_cfg = 0;
    int   w_cfg = 0;
    bit   rt_cfg = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input bit t, input bit a, input bit r);
        exp_t e;
        int   w_eff;
        @(posedge clk);
        #1;
        rst            = r;
        bus.trig       = t;
        bus.abort      = a;
        bus.cfg_delay  = d_cfg[CNT_W-1:0];
        bus.cfg_width  = w_cfg[CNT_W-1:0];
        bus.cfg_retrig = rt_cfg;
        w_eff = (w_cfg == 0) ? 1 : w_cfg;
        e.done = 1'b0;
        e.trig_drop = 1'b0;
        if (r) begin
            m_active = 0;
            m_cnt = 0;
        end else if (a) begin
            e.trig_drop = t;
            m_active = 0;
        end else if (!m_active) begin
            if (t) begin
                m_active = 1;
                m_hi_start = cyc + d_cfg + 1;
                m_hi_end = cyc + d_cfg + w_eff;
            end
        end else if (cyc < m_hi_start) begin
            e.trig_drop = t;
        end else begin
            if (t && rt_cfg) begin
                m_hi_end = cyc + w_eff;
            end else begin
                e.trig_drop = t;
                if (cyc == m_hi_end) begin
                    m_active = 0;
                    e.done = 1'b1;
                    if (m_cnt < CMAX) m_cnt++;
                end
            end
        end
        e.cyc       = cyc + 1;
        e.busy      = m_active;
        e.sig_out   = m_active && (cyc + 1 >= m_hi_start) && (cyc + 1 <= m_hi_end);
        e.pulse_cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.sig_out !== e.sig_out || bus.busy !== e.busy || bus.done !== e.done ||
                bus.trig_drop !== e.trig_drop || int'(bus.pulse_cnt) != e.pulse_cnt ||
                $isunknown(bus.pulse_cnt)) begin
                errors++;
                $display("FAIL cycle %0d outputs: got sig=%b busy=%b done=%b drop=%b cnt=%0d, want sig=%b busy=%b done=%b drop=%b cnt=%0d",
                         cyc, bus.sig_out, bus.busy, bus.done, bus.trig_drop, bus.pulse_cnt,
                         e.sig_out, e.busy, e.done, e.trig_drop, e.pulse_cnt);
            end
        end
    end

    initial begin
        int wait_cnt;
        bus.trig = 0; bus.abort = 0; bus.cfg_delay = 0; bus.cfg_width = 0; bus.cfg_retrig = 0;
        step(0, 0, 1);
        step(0, 0, 1);
        idle(3);

        d_cfg = 0; w_cfg = 4; rt_cfg = 0;
        step(1, 0, 0); idle(8);

        d_cfg = 3; w_cfg = 2;
        step(1, 0, 0); idle(1); step(1, 0, 0); idle(8);

        d_cfg = 0; w_cfg = 0;
        step(1, 0, 0); idle(1); step(1, 0, 0); idle(4);

        d_cfg = 0; w_cfg = 5; rt_cfg = 1;
        step(1, 0, 0); idle(2); step(1, 0, 0); idle(10);
        rt_cfg = 0;
        step(1, 0, 0); idle(2); step(1, 0, 0); idle(10);

        // Retrigger on the last high cycle
        d_cfg = 0; w_cfg = 3; rt_cfg = 1;
        step(1, 0, 0); idle(2); step(1, 0, 0); idle(6);
        rt_cfg = 0;

        d_cfg = 2; w_cfg = 10;
        step(1, 0, 0); idle(4); step(0, 1, 0); idle(6);
        step(1, 0, 0); idle(3); step(0, 0, 1); idle(6);

        d_cfg = 15; w_cfg = 15;
        step(1, 0, 0); step(1, 1, 0); step(0, 1, 0); idle(2);
        step(1, 0, 0); idle(33);

        d_cfg = 0; w_cfg = 0;
        for (int i = 0; i < 17; i++) begin
            step(1, 0, 0); idle(1);
        end
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            bit t, a, r;
            if ($urandom_range(0, 7) == 0) begin
                d_cfg  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
                w_cfg  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
                rt_cfg = $urandom_range(0, 1);
            end
            t = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 299) == 0);
            step(t, a, r);
        end
        idle(2);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
